// File: rtl/tt_um_marno_cnt_if.sv
// Tiny Tapeout user-project pin bundle for tt_um_marno_cnt.
// The master side drives the pins and the slave side is the user design.
interface tt_um_marno_cnt_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena, ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ena, ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_marno_cnt.sv
// WIDTH-bit up/down counter with prescaler, byte-wise load, byte readout and wrap status.
// Define TT_MARNO_GRAY_OUT_EN to present the Gray code of the count on uo_out.
module tt_um_marno_cnt #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned PRESCALE_W = 4
) (
   input logic               clk,
   input logic               rst_n,
   tt_um_marno_cnt_if.slave  bus
);

   localparam int unsigned NBYTES = WIDTH / 8;

   typedef struct packed {
      logic [1:0] psel;
      logic       load;
      logic       dir;
      logic       run;
   } ctrl_t;

   logic                  rst_q;
   logic                  rst_n_i;
   ctrl_t                 s1_q, s1_d, s2_q, s2_d;
   logic                  s3_q, s3_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [WIDTH-1:0]      cnt_q, cnt_d;
   logic                  tc_q, tc_d;
   logic                  sticky_q, sticky_d;

   logic [1:0]            sel;
   logic                  sel_ok;
   logic [PRESCALE_W-1:0] mask;
   logic                  tick;
   logic                  load_p;
   logic                  load_acc;
   logic                  step;
   logic                  wrap;
   logic [WIDTH-1:0]      out_word;
   logic [7:0]            uo;
   logic                  unused_ena;

   // Assert asynchronously, release on the first clk edge after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_q <= 1'b0;
      else        rst_q <= 1'b1;
   end
   assign rst_n_i = rst_q;

   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q     <= '0;
         s2_q     <= '0;
         s3_q     <= 1'b0;
         pre_q    <= '0;
         cnt_q    <= '0;
         tc_q     <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         s3_q     <= s3_d;
         pre_q    <= pre_d;
         cnt_q    <= cnt_d;
         tc_q     <= tc_d;
         sticky_q <= sticky_d;
      end
   end

   assign sel    = bus.ui_in[5:4];
   assign sel_ok = 32'(sel) < NBYTES;

   always_comb begin
      s1_d = {bus.ui_in[7:6], bus.ui_in[3:1]};
      s2_d = s1_q;
      s3_d = s2_q.load;
   end

   always_comb begin
      mask = '0;
      case (s2_q.psel)
         2'b00:   mask = '0;
         2'b01:   mask = PRESCALE_W'(3);
         2'b10:   mask = PRESCALE_W'(15);
         default: mask = '1;
      endcase
   end

   assign tick     = (pre_q & mask) == mask;
   assign load_p   = s2_q.load & ~s3_q;
   assign load_acc = load_p & ~bus.ui_in[0] & sel_ok;
   assign step     = s2_q.run & tick & ~load_acc;
   assign wrap     = step & (s2_q.dir ? (cnt_q == '0) : (cnt_q == '1));

   // An accepted load freezes both the count and the prescaler for that cycle.
   always_comb begin
      pre_d    = pre_q;
      cnt_d    = cnt_q;
      tc_d     = wrap;
      sticky_d = sticky_q | wrap;
      if (!s2_q.run)     pre_d = '0;
      else if (!load_acc) pre_d = pre_q + PRESCALE_W'(1);
      if (load_acc) begin
         sticky_d = 1'b0;
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (32'(sel) == b) cnt_d[b*8 +: 8] = bus.uio_in;
         end
      end else if (step) begin
         cnt_d = s2_q.dir ? cnt_q - WIDTH'(1) : cnt_q + WIDTH'(1);
      end
   end

   always_comb begin
`ifdef TT_MARNO_GRAY_OUT_EN
      out_word = cnt_q ^ (cnt_q >> 1);
`else
      out_word = cnt_q;
`endif
      uo = '0;
      for (int unsigned b = 0; b < NBYTES; b++) begin
         if (32'(sel) == b) uo = out_word[b*8 +: 8];
      end
   end

   assign bus.uo_out  = uo;
   assign bus.uio_out = {5'b0, s2_q.run, sticky_q, tc_q};
   assign bus.uio_oe  = {8{bus.ui_in[0]}};
   assign unused_ena  = bus.ena;

endmodule

// File: tb/tb_tt_um_marno_cnt.sv
// Directed bench for tt_um_marno_cnt: a WIDTH=16 instance for the main features
// and a WIDTH=8 instance for out-of-range byte access.
module tb_tt_um_marno_cnt;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   tt_um_marno_cnt_if bus ();
   tt_um_marno_cnt_if b8 ();

   tt_um_marno_cnt #(.WIDTH(16), .PRESCALE_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   tt_um_marno_cnt #(.WIDTH(8), .PRESCALE_W(4)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic       oe, run, dir, ld;
   logic [1:0] bsel, psel;

   task automatic drive();
      bus.ui_in = {psel, bsel, ld, dir, run, oe};
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] expw(input logic [15:0] c);
      logic [15:0] w;
      w = c;
`ifdef TT_MARNO_GRAY_OUT_EN
      w = c ^ (c >> 1);
`endif
      return w;
   endfunction

   function automatic logic [7:0] exp8(input logic [7:0] c);
      logic [7:0] w;
      w = c;
`ifdef TT_MARNO_GRAY_OUT_EN
      w = c ^ (c >> 1);
`endif
      return w;
   endfunction

   // Reads the 16-bit output word through both byte selects, then restores bsel.
   task automatic read16(output logic [15:0] v);
      logic [1:0] keep;
      keep = bsel;
      bsel = 2'd0; drive(); #1; v[7:0]  = bus.uo_out;
      bsel = 2'd1; drive(); #1; v[15:8] = bus.uo_out;
      bsel = keep; drive(); #1;
   endtask

   task automatic do_load(input logic [1:0] s, input logic [7:0] val);
      bsel = s; bus.uio_in = val; ld = 1'b1; drive();
      tick(1);
      ld = 1'b0; drive();
      tick(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      n_chk++; if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h expected 00", bus.uo_out); end
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h expected 00", bus.uio_out); end
      n_chk++; if (bus.uio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_uio_oe_low: got %h expected 00", bus.uio_oe); end
      oe = 1'b1; drive(); #1;
      n_chk++; if (bus.uio_oe !== 8'hFF) begin n_fail++; $display("FAIL reset_uio_oe_high: got %h expected ff", bus.uio_oe); end
      oe = 1'b0; drive();
      n_chk++; if (b8.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_w8_uo_out: got %h expected 00", b8.uo_out); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_free_run();
      logic [15:0] v;
      run = 1'b1; drive();
      tick(3);
      read16(v);
      n_chk++; if (v !== expw(16'd1)) begin n_fail++; $display("FAIL free_run_first: got %h expected %h", v, expw(16'd1)); end
      for (int i = 2; i <= 8; i++) begin
         tick(1);
         read16(v);
         n_chk++; if (v !== expw(16'(i))) begin n_fail++; $display("FAIL free_run_step%0d: got %h expected %h", i, v, expw(16'(i))); end
      end
      tick(248);
      read16(v);
      n_chk++; if (v !== expw(16'h0100)) begin n_fail++; $display("FAIL free_run_256: got %h expected %h", v, expw(16'h0100)); end
      n_chk++; if (bus.uio_out !== 8'h04) begin n_fail++; $display("FAIL free_run_status: got %h expected 04", bus.uio_out); end
      run = 1'b0; drive();
      tick(4);
      read16(v);
      n_chk++; if (v !== expw(16'h0102)) begin n_fail++; $display("FAIL free_run_freeze: got %h expected %h", v, expw(16'h0102)); end
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL free_run_stopped: got %h expected 00", bus.uio_out); end
   endtask

   task automatic test_load_priority();
      logic [15:0] v;
      run = 1'b1; drive();
      tick(2);
      bsel = 2'd1; bus.uio_in = 8'hA5; ld = 1'b1; drive();
      tick(1);
      ld = 1'b0; drive();
      tick(2);
      read16(v);
      n_chk++; if (v !== expw(16'hA504)) begin n_fail++; $display("FAIL load_priority_load: got %h expected %h", v, expw(16'hA504)); end
      tick(1);
      read16(v);
      n_chk++; if (v !== expw(16'hA505)) begin n_fail++; $display("FAIL load_priority_resume: got %h expected %h", v, expw(16'hA505)); end
      run = 1'b0; drive();
      tick(4);
      read16(v);
      n_chk++; if (v !== expw(16'hA507)) begin n_fail++; $display("FAIL load_priority_stop: got %h expected %h", v, expw(16'hA507)); end
   endtask

   task automatic test_load_gating();
      logic [15:0] v;
      oe = 1'b1; bsel = 2'd1; bus.uio_in = 8'h5A; ld = 1'b1; drive();
      tick(1);
      ld = 1'b0; drive();
      tick(4);
      n_chk++; if (bus.uio_oe !== 8'hFF) begin n_fail++; $display("FAIL gating_uio_oe: got %h expected ff", bus.uio_oe); end
      read16(v);
      n_chk++; if (v !== expw(16'hA507)) begin n_fail++; $display("FAIL gating_cnt: got %h expected %h", v, expw(16'hA507)); end
      oe = 1'b0; drive();
      tick(1);
   endtask

   task automatic test_down_wrap();
      logic [15:0] v;
      do_load(2'd0, 8'h00);
      do_load(2'd1, 8'h00);
      dir = 1'b1; run = 1'b1; drive();
      tick(3);
      n_chk++; if (bus.uio_out !== 8'h07) begin n_fail++; $display("FAIL down_wrap_tc: got %h expected 07", bus.uio_out); end
      read16(v);
      n_chk++; if (v !== expw(16'hFFFF)) begin n_fail++; $display("FAIL down_wrap_cnt: got %h expected %h", v, expw(16'hFFFF)); end
      tick(1);
      n_chk++; if (bus.uio_out !== 8'h06) begin n_fail++; $display("FAIL down_wrap_tc_pulse: got %h expected 06", bus.uio_out); end
      read16(v);
      n_chk++; if (v !== expw(16'hFFFE)) begin n_fail++; $display("FAIL down_wrap_next: got %h expected %h", v, expw(16'hFFFE)); end
      run = 1'b0; drive();
      tick(4);
      n_chk++; if (bus.uio_out !== 8'h02) begin n_fail++; $display("FAIL down_wrap_sticky: got %h expected 02", bus.uio_out); end
      do_load(2'd0, 8'h10);
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL down_wrap_sticky_clear: got %h expected 00", bus.uio_out); end
      read16(v);
      n_chk++; if (v !== expw(16'hFF10)) begin n_fail++; $display("FAIL down_wrap_reload: got %h expected %h", v, expw(16'hFF10)); end
      dir = 1'b0; drive();
   endtask

   task automatic test_up_wrap();
      logic [15:0] v;
      do_load(2'd0, 8'hFF);
      run = 1'b1; drive();
      tick(3);
      n_chk++; if (bus.uio_out !== 8'h07) begin n_fail++; $display("FAIL up_wrap_tc: got %h expected 07", bus.uio_out); end
      read16(v);
      n_chk++; if (v !== expw(16'h0000)) begin n_fail++; $display("FAIL up_wrap_cnt: got %h expected %h", v, expw(16'h0000)); end
      run = 1'b0; drive();
      tick(4);
      read16(v);
      n_chk++; if (v !== expw(16'h0002)) begin n_fail++; $display("FAIL up_wrap_stop: got %h expected %h", v, expw(16'h0002)); end
      n_chk++; if (bus.uio_out !== 8'h02) begin n_fail++; $display("FAIL up_wrap_sticky: got %h expected 02", bus.uio_out); end
   endtask

   task automatic test_prescaler();
      logic [15:0] v;
      do_load(2'd0, 8'h00);
      do_load(2'd1, 8'h00);
      psel = 2'b01; run = 1'b1; drive();
      tick(2);
      for (int k = 3; k <= 14; k++) begin
         tick(1);
         read16(v);
         n_chk++; if (v !== expw(16'((k - 2) / 4))) begin n_fail++; $display("FAIL prescale4_edge%0d: got %h expected %h", k, v, expw(16'((k - 2) / 4))); end
      end
      run = 1'b0; drive();
      tick(4);
      do_load(2'd0, 8'h00);
      psel = 2'b11; run = 1'b1; drive();
      tick(17);
      read16(v);
      n_chk++; if (v !== expw(16'd0)) begin n_fail++; $display("FAIL prescale16_before: got %h expected %h", v, expw(16'd0)); end
      tick(1);
      read16(v);
      n_chk++; if (v !== expw(16'd1)) begin n_fail++; $display("FAIL prescale16_first: got %h expected %h", v, expw(16'd1)); end
      tick(15);
      read16(v);
      n_chk++; if (v !== expw(16'd1)) begin n_fail++; $display("FAIL prescale16_hold: got %h expected %h", v, expw(16'd1)); end
      tick(1);
      read16(v);
      n_chk++; if (v !== expw(16'd2)) begin n_fail++; $display("FAIL prescale16_second: got %h expected %h", v, expw(16'd2)); end
      run = 1'b0; drive();
      tick(10);
      read16(v);
      n_chk++; if (v !== expw(16'd2)) begin n_fail++; $display("FAIL prescale_freeze: got %h expected %h", v, expw(16'd2)); end
      // A cleared prescaler restarts the /4 phase from zero.
      psel = 2'b01; run = 1'b1; drive();
      tick(5);
      read16(v);
      n_chk++; if (v !== expw(16'd2)) begin n_fail++; $display("FAIL prescale_restart_hold: got %h expected %h", v, expw(16'd2)); end
      tick(1);
      read16(v);
      n_chk++; if (v !== expw(16'd3)) begin n_fail++; $display("FAIL prescale_restart_step: got %h expected %h", v, expw(16'd3)); end
      run = 1'b0; psel = 2'b00; drive();
      tick(4);
   endtask

   task automatic test_out_of_range();
      b8.uio_in = 8'h3C; b8.ui_in = 8'b0000_1000;
      tick(1);
      b8.ui_in = 8'h00;
      tick(2);
      n_chk++; if (b8.uo_out !== exp8(8'h3C)) begin n_fail++; $display("FAIL w8_load: got %h expected %h", b8.uo_out, exp8(8'h3C)); end
      b8.ui_in = 8'b0010_0000; #1;
      n_chk++; if (b8.uo_out !== 8'h00) begin n_fail++; $display("FAIL w8_read_byte2: got %h expected 00", b8.uo_out); end
      b8.ui_in = 8'b0001_0000; #1;
      n_chk++; if (b8.uo_out !== 8'h00) begin n_fail++; $display("FAIL w8_read_byte1: got %h expected 00", b8.uo_out); end
      b8.uio_in = 8'h77; b8.ui_in = 8'b0010_1000;
      tick(1);
      b8.ui_in = 8'b0010_0000;
      tick(2);
      b8.ui_in = 8'h00; #1;
      n_chk++; if (b8.uo_out !== exp8(8'h3C)) begin n_fail++; $display("FAIL w8_load_byte2_ignored: got %h expected %h", b8.uo_out, exp8(8'h3C)); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] v;
      run = 1'b1; drive();
      tick(5);
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      n_chk++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_mid_status: got %h expected 00", bus.uio_out); end
      n_chk++; if (b8.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_mid_w8: got %h expected 00", b8.uo_out); end
      read16(v);
      n_chk++; if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_cnt: got %h expected 0000", v); end
      tick(2);
      rst_n = 1'b1;
      tick(3);
      read16(v);
      n_chk++; if (v !== expw(16'd0)) begin n_fail++; $display("FAIL reset_mid_held: got %h expected %h", v, expw(16'd0)); end
      tick(1);
      read16(v);
      n_chk++; if (v !== expw(16'd1)) begin n_fail++; $display("FAIL reset_mid_resume1: got %h expected %h", v, expw(16'd1)); end
      tick(1);
      read16(v);
      n_chk++; if (v !== expw(16'd2)) begin n_fail++; $display("FAIL reset_mid_resume2: got %h expected %h", v, expw(16'd2)); end
      run = 1'b0; drive();
      tick(4);
   endtask

`ifdef TT_MARNO_GRAY_OUT_EN
   task automatic test_gray();
      logic [15:0] v, prev;
      do_load(2'd0, 8'h03);
      do_load(2'd1, 8'h00);
      bsel = 2'd0; drive(); #1;
      n_chk++; if (bus.uo_out !== 8'h02) begin n_fail++; $display("FAIL gray_byte0: got %h expected 02", bus.uo_out); end
      read16(prev);
      run = 1'b1; drive();
      tick(3);
      for (int i = 0; i < 20; i++) begin
         read16(v);
         n_chk++; if ($countones(v ^ prev) != 1) begin n_fail++; $display("FAIL gray_one_bit%0d: got %h after %h expected one changed bit", i, v, prev); end
         prev = v;
         tick(1);
      end
      run = 1'b0; drive();
      tick(4);
   endtask
`endif

   initial begin
      oe = 1'b0; run = 1'b0; dir = 1'b0; ld = 1'b0; bsel = 2'd0; psel = 2'd0;
      drive();
      bus.uio_in = 8'h00; bus.ena = 1'b1;
      b8.ui_in = 8'h00; b8.uio_in = 8'h00; b8.ena = 1'b1;
      test_reset();
      test_free_run();
      test_load_priority();
      test_load_gating();
      test_down_wrap();
      test_up_wrap();
      test_prescaler();
      test_out_of_range();
      test_reset_mid();
`ifdef TT_MARNO_GRAY_OUT_EN
      test_gray();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_marno_cnt.md
# tt_um_marno_cnt

Parametrised Tiny Tapeout user counter block, the successor of the team's fixed 8-bit free-running counter demo. It provides a WIDTH-bit up/down counter with a selectable prescaler, byte-wise parallel load from the bidirectional pins, byte-selectable readout and wrap status. It sits directly behind the standard TT user-project pin interface.

## Interface
- WIDTH, 16, counter width in bits; multiple of 8, range 8..32.
- PRESCALE_W, 4, prescaler counter width in bits; range 4..8.

- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  TT design enable; ignored.
- ui_in  in  8  controls:
  - [0] oe: uio pins become outputs.
  - [1] run.
  - [2] dir: 0 up, 1 down.
  - [3] load strobe.
  - [5:4] byte select.
  - [7:6] prescale select.
- uo_out  out  8  selected byte of the counter (binary or Gray, see Configuration).
- uio_in  in  8  load data byte.
- uio_out  out  8  status: [0] tc, [1] wrap_sticky, [2] running, [7:3] 0.
- uio_oe  out  8  {8{ui_in[0]}}.

## Operation
- Internal reset rst_n_i:
  - Asserts asynchronously with rst_n.
  - Releases on the first clk rising edge after rst_n rises.
  - Clears every register below.
- Synchroniser: ui_in[3:1] and ui_in[7:6] pass through a 2-flop synchroniser (s1, s2). Byte select ui_in[5:4] and oe ui_in[0] are combinational.
- Load edge: s3 holds the previous s2[3]; load_p = s2[3] & ~s3.
- Prescaler:
  - PRESCALE_W-bit counter pre, incrementing each cycle while s2 run=1; cleared while run=0.
  - tick when the low N bits of pre are all ones.
  - N = 0, 2, 4 or PRESCALE_W for select 00, 01, 10, 11. N=0 gives a tick every cycle.
- Counter step: when run & tick, cnt ← cnt+1 (dir=0) or cnt−1 (dir=1), modulo 2^WIDTH.
- Load:
  - When load_p and ui_in[0]=0, byte ui_in[5:4] of cnt ← uio_in. Other bytes are unchanged.
  - Load is ignored when ui_in[0]=1.
  - Load is ignored for a byte index ≥ WIDTH/8.
  - Load has priority over a step in the same cycle: no step occurs and pre is not disturbed.
- Wrap:
  - A wrap is a step from all-ones to 0 (up) or from 0 to all-ones (down).
  - tc is a registered 1-cycle pulse on the cycle after a wrap.
  - wrap_sticky sets with tc and clears on any accepted load.
  - Loads never generate tc.
- running = s2 run.
- Readout: uo_out = byte ui_in[5:4] of the output word. Byte index ≥ WIDTH/8 reads 0x00.

## Timing
- Reset values:
  - cnt=0, pre=0, tc=0, wrap_sticky=0, s1/s2/s3=0.
  - uo_out=0x00.
  - uio_out=0x00.
  - uio_oe follows ui_in[0] combinationally at all times.
- Control latency: run, dir and prescale select take effect 2 cycles after the pin changes.
- Load latency:
  - ui_in[3] sampled high at edge k.
  - cnt updated at edge k+2.
  - New value visible on uo_out after edge k+2.
- Step latency: count change is visible after the edge on which run & tick is true. tc is high during the following cycle.
- Prescale /4: cnt changes every 4th cycle while running. /16 and /2^PRESCALE_W behave likewise.
- Reset mid-operation: all state clears immediately. Counting resumes no earlier than 3 edges after rst_n rises (1 for reset release, 2 for synchronisation).
- Holding ui_in[3] high produces a single load. Re-arming requires ui_in[3] low for ≥1 synchronised sample.

## Configuration
- TT_MARNO_GRAY_OUT_EN:
  - Defined: the output word is the Gray code cnt ^ (cnt >> 1), taken over the full WIDTH and then byte-selected.
  - Undefined: the output word is binary cnt.
- Status, load and stepping are identical in both builds.

## Test plan
- Reset + free-run, WIDTH=16, select 00, run=1, dir=0, byte 0: after sync, uo_out increments by 1 per clk. At 256 steps, byte 1 reads 0x01.
- Down wrap: load 0x00 into bytes 0 and 1, dir=1, run=1. The first step gives cnt=0xFFFF, tc=1 for exactly 1 cycle, and wrap_sticky=1 until the next load.
- Load priority and gating:
  - uio_in=0xA5 with load while running, byte 1: cnt[15:8]=0xA5, no step that cycle.
  - Same stimulus with ui_in[0]=1: cnt is unchanged.
- Prescaler: select 01 gives exactly 1 step per 4 clks. Select 11 with PRESCALE_W=4 gives 1 step per 16 clks. run=0 freezes cnt and clears pre.
- Out-of-range byte: WIDTH=8, byte select 2 reads 0x00, and a load to byte 2 leaves cnt unchanged.
- Gray build (TT_MARNO_GRAY_OUT_EN defined): cnt=0x0003 reads 0x02 on byte 0. Consecutive up steps change exactly one bit of the 16-bit output word.
